// File: rtl/urng_pkg.sv
// Shared types, constants and the Tausworthe step function for the URNG scheduler.
package urng_pkg;

  typedef enum logic [1:0] {
    ST_SEED,
    ST_WARMUP,
    ST_SERVE
  } state_t;

  // Smallest legal seed per component; smaller values degenerate the recurrence.
  localparam logic [31:0] SEED0_MIN = 32'd2;
  localparam logic [31:0] SEED1_MIN = 32'd8;
  localparam logic [31:0] SEED2_MIN = 32'd16;

  localparam logic [31:0] MASK0 = 32'hFFFF_FFFE;
  localparam logic [31:0] MASK1 = 32'hFFFF_FFF8;
  localparam logic [31:0] MASK2 = 32'hFFFF_FFF0;

  typedef struct packed {
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
  } seeds_t;

  // One step of the three-component Tausworthe recurrence.
  function automatic seeds_t taus_step(input logic [31:0] s0,
                                       input logic [31:0] s1,
                                       input logic [31:0] s2);
    seeds_t      n;
    logic [31:0] b;
    b    = ((s0 << 13) ^ s0) >> 19;
    n.s0 = ((s0 & MASK0) << 12) ^ b;
    b    = ((s1 << 2) ^ s1) >> 25;
    n.s1 = ((s1 & MASK1) << 4) ^ b;
    b    = ((s2 << 3) ^ s2) >> 11;
    n.s2 = ((s2 & MASK2) << 17) ^ b;
    return n;
  endfunction

  function automatic logic seeds_ok(input logic [31:0] s0,
                                    input logic [31:0] s1,
                                    input logic [31:0] s2);
    return (s0 >= SEED0_MIN) && (s1 >= SEED1_MIN) && (s2 >= SEED2_MIN);
  endfunction

endpackage

// File: rtl/urng_taus_core.sv
// Tausworthe generator core: three seed registers, load or step per cycle.
module urng_taus_core
  import urng_pkg::*;
#(
  parameter logic [31:0] SEED0_DEF = 32'h0000_1234,
  parameter logic [31:0] SEED1_DEF = 32'h0000_5678,
  parameter logic [31:0] SEED2_DEF = 32'h0009_ABCD
) (
  input  logic        clock,
  input  logic        re_set,
  input  logic        load,
  input  logic [31:0] seed0,
  input  logic [31:0] seed1,
  input  logic [31:0] seed2,
  input  logic        step,
  output logic [31:0] out
);

  seeds_t s;
  seeds_t s_next;

  assign s_next = taus_step(s.s0, s.s1, s.s2);
  assign out    = s.s0 ^ s.s1 ^ s.s2;

  // Seed state: load has priority over step.
  always_ff @(posedge clock or posedge re_set) begin
    if (re_set)    s <= {SEED0_DEF, SEED1_DEF, SEED2_DEF};
    else if (load) s <= {seed0, seed1, seed2};
    else if (step) s <= s_next;
  end

endmodule

// File: rtl/urng_scheduler.sv
// Seed sequencer, warm-up controller and round-robin arbiter sharing one URNG core.
module urng_scheduler
  import urng_pkg::*;
#(
  parameter int          NREQ      = 4,
  parameter int          WARMUP    = 16,
  parameter logic [31:0] SEED0_DEF = 32'h0000_1234,
  parameter logic [31:0] SEED1_DEF = 32'h0000_5678,
  parameter logic [31:0] SEED2_DEF = 32'h0009_ABCD
) (
  input  logic            clock,
  input  logic            re_set,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [31:0]     rnd_data,
  output logic            rnd_valid,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  input  logic            cfg_start,
  output logic            busy,
  output logic            seed_err
);

  localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NR = NREQ;

  state_t          state, state_n;
  logic [7:0]      wcnt, wcnt_n;
  logic [PW-1:0]   ptr, ptr_n, win;
  logic [NREQ-1:0] gnt_n;
  logic [31:0]     rnd_n;
  logic            seed_err_n;
  logic            found;
  int unsigned     idx;
  logic            commit_ok;
  logic            core_load, core_step;
  logic [31:0]     core_out;
  logic [31:0]     sh0, sh1, sh2;
  logic [31:0]     cm0, cm1, cm2;

  urng_taus_core #(
    .SEED0_DEF(SEED0_DEF),
    .SEED1_DEF(SEED1_DEF),
    .SEED2_DEF(SEED2_DEF)
  ) u_core (
    .clock (clock),
    .re_set(re_set),
    .load  (core_load),
    .seed0 (cm0),
    .seed1 (cm1),
    .seed2 (cm2),
    .step  (core_step),
    .out   (core_out)
  );

  assign busy      = (state != ST_SERVE);
  assign commit_ok = seeds_ok(sh0, sh1, sh2);

  // State register.
  always_ff @(posedge clock or posedge re_set) begin
    if (re_set) state <= ST_SEED;
    else        state <= state_n;
  end

  // Next state, arbitration and core control; cfg_start overrides the case decisions.
  always_comb begin
    state_n    = state;
    wcnt_n     = wcnt;
    ptr_n      = ptr;
    gnt_n      = '0;
    rnd_n      = rnd_data;
    seed_err_n = 1'b0;
    core_load  = 1'b0;
    core_step  = 1'b0;
    found      = 1'b0;
    win        = '0;
    idx        = 0;

    for (int unsigned k = 0; k < NR; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NR) idx = idx - NR;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end

    case (state)
      ST_SEED: begin
        core_load = 1'b1;
        wcnt_n    = '0;
        state_n   = ST_WARMUP;
      end
      ST_WARMUP: begin
        core_step = 1'b1;
        wcnt_n    = wcnt + 8'd1;
        if (wcnt == 8'(WARMUP - 1)) state_n = ST_SERVE;
      end
      ST_SERVE: begin
        if (!cfg_start && found) begin
          gnt_n[win] = 1'b1;
          rnd_n      = core_out;
          core_step  = 1'b1;
          ptr_n      = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      end
      default: state_n = ST_SEED;
    endcase

    if (cfg_start) begin
      if (commit_ok) state_n    = ST_SEED;
      else           seed_err_n = 1'b1;
    end
  end

  // Output, pointer and warm-up counter registers.
  always_ff @(posedge clock or posedge re_set) begin
    if (re_set) begin
      gnt       <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
      seed_err  <= 1'b0;
      ptr       <= '0;
      wcnt      <= '0;
    end else begin
      gnt       <= gnt_n;
      rnd_data  <= rnd_n;
      rnd_valid <= |gnt_n;
      seed_err  <= seed_err_n;
      ptr       <= ptr_n;
      wcnt      <= wcnt_n;
    end
  end

  // Shadow seeds and the committed copy the SEED state loads from; the commit
  // snapshots the shadows so same-cycle or later writes cannot leak into the load.
  always_ff @(posedge clock or posedge re_set) begin
    if (re_set) begin
      sh0 <= SEED0_DEF;
      sh1 <= SEED1_DEF;
      sh2 <= SEED2_DEF;
      cm0 <= SEED0_DEF;
      cm1 <= SEED1_DEF;
      cm2 <= SEED2_DEF;
    end else begin
      if (cfg_start && commit_ok) begin
        cm0 <= sh0;
        cm1 <= sh1;
        cm2 <= sh2;
      end
      if (cfg_we) begin
        case (cfg_addr)
          2'd0:    sh0 <= cfg_wdata;
          2'd1:    sh1 <= cfg_wdata;
          2'd2:    sh2 <= cfg_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/urng_scheduler.md
# urng_scheduler

Sequencer and round-robin arbiter for the 32-bit three-component Tausworthe URNG. It loads and validates seeds, runs a warm-up discard phase, and then shares one generator among NREQ requesters, one word per grant. It sits between the noise-generator datapath consumers and a private URNG core instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- WARMUP, 16, generator steps discarded after every seed load (1..255)
- SEED0_DEF, 32'h0000_1234, default seed, component 0 (must be > 1)
- SEED1_DEF, 32'h0000_5678, default seed, component 1 (must be > 7)
- SEED2_DEF, 32'h0009_ABCD, default seed, component 2 (must be > 15)

Ports:
- clock  in  1  single clock, rising edge
- re_set  in  1  asynchronous reset, active-high
- req  in  NREQ  request per requester, level
- gnt  out  NREQ  one-hot grant pulse
- rnd_data  out  32  random word, registered
- rnd_valid  out  1  rnd_data valid; high exactly on grant cycles
- cfg_we  in  1  shadow seed write strobe
- cfg_addr  in  2  shadow seed select 0..2; 3 is ignored
- cfg_wdata  in  32  shadow seed value
- cfg_start  in  1  commit shadow seeds and restart the sequence
- busy  out  1  high in SEED/WARMUP; no grants issued
- seed_err  out  1  one-cycle pulse when a commit is rejected

## Operation
- States: SEED, WARMUP, SERVE. Reset enters SEED with the shadow registers equal to the SEED*_DEF values.
- Shadow writes:
  - Accepted in any state when cfg_we is high.
  - They do not affect the running generator until commit.
- SEED (1 cycle):
  - Loads the active seeds into the core from the shadows.
  - Clears the warm-up counter.
  - Goes to WARMUP.
- WARMUP:
  - The core steps every cycle and output is discarded.
  - After WARMUP steps, goes to SERVE.
- SERVE:
  - Each cycle that any req bit is high, grants exactly one requester, round-robin.
  - The search starts at the index after the last grant; the pointer is 0 after reset.
  - The core steps only on grant cycles.
  - On a grant cycle, rnd_data is the core output before the step. Each word is delivered once.
- Arbitration details:
  - A requester holding req high is re-granted every NREQ cycles at worst.
  - A requester that is alone is granted every cycle.
- Commit (cfg_start in any state):
  - Shadow seeds must satisfy s0>1, s1>7, s2>15.
  - Valid commit: go to SEED next cycle. Any in-progress warm-up restarts.
  - Invalid commit: seed_err pulses, state and active seeds are unchanged, and the shadows keep the written values.
- Simultaneous events:
  - cfg_start with req in SERVE: cfg_start wins and no grant is issued that cycle.
  - cfg_we with cfg_start in the same cycle: the commit uses the pre-write shadows.
- Core recurrence per step:
  - b=((s0<<13)^s0)>>19; s0=((s0&FFFFFFFE)<<12)^b
  - b=((s1<<2)^s1)>>25; s1=((s1&FFFFFFF8)<<4)^b
  - b=((s2<<3)^s2)>>11; s2=((s2&FFFFFFF0)<<17)^b
  - Output = s0^s1^s2. All arithmetic is 32-bit unsigned and overflow bits are dropped.

## Timing
- Reset values: gnt=0, rnd_data=0, rnd_valid=0, busy=1, seed_err=0, round-robin pointer=0.
- After reset release: 1 cycle SEED + WARMUP cycles, then SERVE. The first grant can occur in cycle WARMUP+2.
- Grant latency:
  - req sampled at cycle N gives gnt/rnd_valid/rnd_data registered at N+1.
  - Dropping req at N leaves no grant at N+1 for that requester.
- Commit latency:
  - cfg_start at N gives busy=1 at N+1 (SEED), then SERVE after WARMUP more cycles.
  - seed_err is asserted at N+1 for an invalid commit.
- Reset mid-operation: the async clear takes effect immediately; shadows and active seeds return to their defaults.

## Structure
- Package urng_pkg:
  - state enum {SEED, WARMUP, SERVE}.
  - Seed minimum constants 2, 8, 16.
  - Mask constants FFFFFFFE, FFFFFFF8, FFFFFFF0.
  - A function taus_step(s0, s1, s2) that returns the next seeds.
- Sub-module urng_taus_core:
  - Holds the three seed registers.
  - Ports: load, seed0..2, step, out.
  - Uses the same clock and reset as the scheduler.
  - The scheduler owns the FSM, the arbiter, the shadows and the output registers.

## Test plan
- Reset, defaults, no req -> busy high for 17 cycles then low; gnt=0 throughout; the first word granted equals the golden model output after 16 discarded steps.
- req=4'b1111 held in SERVE -> gnt cycles 0001, 0010, 0100, 1000, 0001; rnd_data is consecutive model words with no repeats.
- req=4'b0101 -> gnt alternates 0001, 0100; req=4'b0100 alone -> gnt=0100 every cycle.
- Write cfg_addr 1 = 32'h7, then cfg_start -> seed_err pulses one cycle; grant stream continues unchanged with the old sequence.
- Write seeds 2/8/16, cfg_start while req=1111 -> no grant that cycle; busy for 17 cycles; output matches the model seeded 2/8/16.
- Assert re_set mid-WARMUP after a custom commit -> outputs return to reset values immediately; the sequence restarts from the default seeds.
